// File: rtl/mux_8x1_rr_if.sv
// -----------------------------------------------------------------------------
// mux_8x1_rr_if
// Bundle of the eight input channel streams and the single merged output
// stream of the 8-to-1 round-robin multiplexer.
//
//   in_valid  [7:0]          per-channel beat valid (bit i = channel i)
//   in_data   [8*DATA_W-1:0] channel i at [i*DATA_W +: DATA_W]
//   in_last   [7:0]          per-channel end-of-packet, qualified by in_valid
//   in_ready  [7:0]          per-channel accept, one-hot or zero
//   out_valid                output register holds a beat
//   out_ready                downstream accept
//   out_data  [DATA_W-1:0]   registered beat data
//   out_sel   [2:0]          source channel of the held beat
//   out_last                 end-of-packet flag of the held beat
//
// Modports: slave = the multiplexer, master = whatever drives the channels
// and consumes the merged stream.
// -----------------------------------------------------------------------------
interface mux_8x1_rr_if #(
    parameter int DATA_W = 8
);
    logic [7:0]          in_valid;
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_last;
    logic [7:0]          in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;
    logic                out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/mux_8x1_rr.sv
// -----------------------------------------------------------------------------
// mux_8x1_rr
// Registered 8-to-1 round-robin multiplexer. Merges up to eight valid/ready
// channel streams into one output stream; every output beat is tagged with
// its source channel (out_sel). Multi-beat packets framed by in_last are
// never interleaved: once a channel starts a packet it owns the output until
// its last beat.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux_8x1_rr_if.slave (channel inputs, merged output)
// -----------------------------------------------------------------------------
module mux_8x1_rr #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_8x1_rr_if.slave       bus
);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t state, state_nxt;

    logic [2:0]        ptr, ptr_nxt;
    logic [2:0]        lock_ch, lock_ch_nxt;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [2:0]        out_sel_q;
    logic              out_last_q;

    logic              slot_free;
    logic [2:0]        grant;
    logic              grant_vld;
    logic [2:0]        sel_ch;
    logic              sel_vld;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;

    assign slot_free = ~out_valid_q | bus.out_ready;

    // Round-robin scan starting at ptr; the first valid channel wins.
    // NOTE: every variable written in a combinational block gets a default
    // first, otherwise paths that skip an assignment infer a latch.
    always_comb begin
        logic [2:0] idx;
        grant     = ptr;
        grant_vld = 1'b0;
        idx       = ptr;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!grant_vld && bus.in_valid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    // While locked the owning channel is the only candidate, even when idle.
    assign sel_ch  = (state == LOCKED) ? lock_ch : grant;
    assign sel_vld = (state == LOCKED) ? 1'b1    : grant_vld;
    assign xfer    = rst_n & slot_free & sel_vld & bus.in_valid[sel_ch];

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel_ch == 3'(i)) begin
                sel_data = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: a last beat releases the output and moves the
    // pointer past the winner; a non-last beat locks onto its channel.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        lock_ch_nxt = lock_ch;
        if (xfer) begin
            if (bus.in_last[sel_ch]) begin
                ptr_nxt   = sel_ch + 3'd1;
                state_nxt = ARB;
            end else begin
                lock_ch_nxt = sel_ch;
                state_nxt   = LOCKED;
            end
        end
    end

    // Output decode: in_ready depends only on rst_n, out_ready, state, ptr
    // and in_valid, never on in_data or in_last.
    always_comb begin
        bus.in_ready = '0;
        if (rst_n && sel_vld && slot_free) begin
            bus.in_ready[sel_ch] = 1'b1;
        end
    end

    // State and output register. Reset is sampled on the clock edge only, so
    // a reset mid-packet simply discards the held beat and the lock.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB;
            ptr         <= '0;
            lock_ch     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lock_ch <= lock_ch_nxt;
            if (xfer) begin
                // Drain and reload in the same cycle: no bubble.
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_sel_q   <= sel_ch;
                out_last_q  <= bus.in_last[sel_ch];
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mux_8x1_rr.sv
// -----------------------------------------------------------------------------
// tb_mux_8x1_rr
// Self-checking bench for mux_8x1_rr: directed scenarios with explicit
// expected values, plus a randomized run checked against a transaction-level
// model of the round-robin merge.
// -----------------------------------------------------------------------------
module tb_mux_8x1_rr;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    mux_8x1_rr_if #(.DATA_W(DW)) bus ();

    mux_8x1_rr #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; lands 1 time unit after the falling edge, well away
    // from the rising edge where the DUT samples.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < 8; i++) bus.in_data[i*DW +: DW] = base + 8'(i);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b0;
        set_data(8'h00);
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 8'hFF;
        bus.in_last   = 8'hFF;
        bus.out_ready = 1'b0;
        set_data(8'h10);
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (bus.in_ready !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_in_ready cycle %0d: got %h want 00", c, bus.in_ready);
            end
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.out_sel !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_out cycle %0d: got valid=%b sel=%0d want valid=0 sel=0",
                         c, bus.out_valid, bus.out_sel);
            end
        end
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 8'h01) begin
            miscompares++;
            $display("FAIL release_in_ready: got %h want 01", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd0 || bus.out_data !== 8'h10) begin
            miscompares++;
            $display("FAIL first_beat: got valid=%b sel=%0d data=%h want valid=1 sel=0 data=10",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        bus.in_valid  = 8'hFF;
        bus.in_last   = 8'hFF;
        bus.out_ready = 1'b1;
        set_data(8'h10);
        #1;
        for (int j = 0; j < 10; j++) begin
            vectors++;
            if (bus.in_ready !== 8'(1 << (j % 8))) begin
                miscompares++;
                $display("FAIL rot_in_ready cycle %0d: got %h want %h", j, bus.in_ready, 8'(1 << (j % 8)));
            end
            if (j > 0) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'((j - 1) % 8) ||
                    bus.out_data !== 8'(8'h10 + (j - 1) % 8)) begin
                    miscompares++;
                    $display("FAIL rot_beat cycle %0d: got valid=%b sel=%0d data=%h want valid=1 sel=%0d data=%h",
                             j, bus.out_valid, bus.out_sel, bus.out_data, (j - 1) % 8, 8'(8'h10 + (j - 1) % 8));
                end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_rdy [3];
        logic [2:0] exp_sel [3];
        exp_rdy = '{8'h04, 8'h40, 8'h04};
        exp_sel = '{3'd2, 3'd6, 3'd2};
        do_reset();
        bus.in_valid  = 8'h44;
        bus.in_last   = 8'hFF;
        bus.out_ready = 1'b1;
        set_data(8'h30);
        #1;
        for (int j = 0; j < 3; j++) begin
            vectors++;
            if (bus.in_ready !== exp_rdy[j]) begin
                miscompares++;
                $display("FAIL wrap_in_ready cycle %0d: got %h want %h", j, bus.in_ready, exp_rdy[j]);
            end
            step();
            vectors++;
            if (bus.out_sel !== exp_sel[j] || bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_sel beat %0d: got valid=%b sel=%0d want valid=1 sel=%0d",
                         j, bus.out_valid, bus.out_sel, exp_sel[j]);
            end
        end
    endtask

    task automatic test_packet_lock();
        do_reset();
        bus.in_valid  = 8'h18;
        bus.out_ready = 1'b1;
        set_data(8'h40);
        for (int j = 0; j < 4; j++) begin
            bus.in_last = (j == 3) ? 8'h18 : 8'h10;
            bus.in_data[3*DW +: DW] = 8'(8'hC0 + j);
            #1;
            vectors++;
            if (bus.in_ready !== 8'h08) begin
                miscompares++;
                $display("FAIL lock_in_ready beat %0d: got %h want 08", j, bus.in_ready);
            end
            step();
            vectors++;
            if (bus.out_sel !== 3'd3 || bus.out_data !== 8'(8'hC0 + j) || bus.out_last !== (j == 3)) begin
                miscompares++;
                $display("FAIL lock_beat %0d: got sel=%0d data=%h last=%b want sel=3 data=%h last=%b",
                         j, bus.out_sel, bus.out_data, bus.out_last, 8'(8'hC0 + j), (j == 3));
            end
        end
        bus.in_valid = 8'h10;
        #1;
        vectors++;
        if (bus.in_ready !== 8'h10) begin
            miscompares++;
            $display("FAIL lock_release_in_ready: got %h want 10", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_sel !== 3'd4 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_next_grant: got valid=%b sel=%0d want valid=1 sel=4", bus.out_valid, bus.out_sel);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.in_valid  = 8'h01;
        bus.in_last   = 8'h01;
        bus.out_ready = 1'b0;
        bus.in_data[0 +: DW] = 8'hA5;
        #1;
        vectors++;
        if (bus.in_ready !== 8'h01) begin
            miscompares++;
            $display("FAIL bp_first_in_ready: got %h want 01", bus.in_ready);
        end
        step();
        bus.in_data[0 +: DW] = 8'h5A;
        #1;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (bus.in_ready !== 8'h00 || bus.out_valid !== 1'b1 ||
                bus.out_data !== 8'hA5 || bus.out_sel !== 3'd0) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: got rdy=%h valid=%b data=%h sel=%0d want rdy=00 valid=1 data=a5 sel=0",
                         c, bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 8'h01) begin
            miscompares++;
            $display("FAIL bp_release_in_ready: got %h want 01", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL bp_no_bubble: got valid=%b data=%h want valid=1 data=5a", bus.out_valid, bus.out_data);
        end
        bus.in_valid = 8'h00;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.in_valid  = 8'h20;
        bus.in_last   = 8'h00;
        bus.out_ready = 1'b1;
        set_data(8'h50);
        #1;
        vectors++;
        if (bus.in_ready !== 8'h20) begin
            miscompares++;
            $display("FAIL rmp_beat1_in_ready: got %h want 20", bus.in_ready);
        end
        step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL rmp_in_ready_in_reset: got %h want 00", bus.in_ready);
        end
        step();
        rst_n        = 1'b1;
        bus.in_valid = 8'h21;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rmp_out_valid: got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.in_ready !== 8'h01) begin
            miscompares++;
            $display("FAIL rmp_arb_ptr0: got %h want 01", bus.in_ready);
        end
        step();
        vectors++;
        if (bus.out_sel !== 3'd0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rmp_first_grant: got valid=%b sel=%0d want valid=1 sel=0", bus.out_valid, bus.out_sel);
        end
    endtask

    // Randomized traffic against a transaction-level model: each channel
    // holds at most one pending beat, kept until the model says it was taken.
    task automatic test_random();
        bit   [7:0] vld;
        bit   [7:0] lst;
        logic [7:0] dat [8];
        int         m_ptr, m_lock, ch;
        bit         m_locked, m_ov, m_ol, slot, found, acc;
        logic [7:0] m_od;
        int         m_os;
        logic [7:0] exp_rdy;

        do_reset();
        m_ptr = 0; m_lock = 0; m_locked = 0;
        m_ov = 0; m_od = 0; m_os = 0; m_ol = 0;
        vld = '0; lst = '0;
        for (int i = 0; i < 8; i++) dat[i] = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 8; i++) begin
                if (!vld[i] && $urandom_range(0, 99) < 35) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                    lst[i] = ($urandom_range(0, 2) != 0);
                end
                bus.in_data[i*DW +: DW] = dat[i];
            end
            bus.in_valid  = vld;
            bus.in_last   = lst;
            bus.out_ready = ($urandom_range(0, 99) < 75);
            #1;

            slot  = !m_ov || bus.out_ready;
            found = 1'b0;
            ch    = 0;
            if (m_locked) begin
                ch    = m_lock;
                found = 1'b1;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (!found && vld[(m_ptr + k) % 8]) begin
                        ch    = (m_ptr + k) % 8;
                        found = 1'b1;
                    end
                end
            end
            exp_rdy = '0;
            if (found && slot) exp_rdy[ch] = 1'b1;

            vectors++;
            if (bus.in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rand_in_ready cycle %0d: got %h want %h", cyc, bus.in_ready, exp_rdy);
            end
            vectors++;
            if (bus.out_valid !== m_ov || bus.out_data !== m_od ||
                bus.out_sel !== 3'(m_os) || bus.out_last !== m_ol) begin
                miscompares++;
                $display("FAIL rand_out cycle %0d: got v=%b d=%h s=%0d l=%b want v=%b d=%h s=%0d l=%b",
                         cyc, bus.out_valid, bus.out_data, bus.out_sel, bus.out_last,
                         m_ov, m_od, m_os, m_ol);
            end

            acc = found && slot && vld[ch];
            if (acc) begin
                m_ov = 1'b1;
                m_od = dat[ch];
                m_os = ch;
                m_ol = lst[ch];
                if (lst[ch]) begin
                    m_ptr    = (ch + 1) % 8;
                    m_locked = 1'b0;
                end else begin
                    m_lock   = ch;
                    m_locked = 1'b1;
                end
                vld[ch] = 1'b0;
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_rotation();
        test_wrap();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_8x1_rr.md
Name: mux_8x1_rr

Overview:
- Registered 8-to-1 round-robin multiplexer. It is the merge-side counterpart of the 8-way demux: it collects up to 8 valid/ready channel streams into one output stream.
- Each output beat carries out_sel, the 3-bit source channel index, so a downstream demux can route the beat back by channel.
- Multi-beat packets (framed by in_last) are never interleaved.

Parameters:
- DATA_W, 8, data width per channel and at the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  8  per-channel beat valid; bit i = channel i
- in_data  input  8*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_last  input  8  per-channel end-of-packet flag, qualified by in_valid[i]
- in_ready  output  8  per-channel accept; one-hot or zero
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accept
- out_data  output  DATA_W  registered beat data
- out_sel  output  3  source channel of the current beat
- out_last  output  1  registered copy of in_last for the beat

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: sampled only on the clk rising edge while rst_n=0.
  - Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, rr pointer ptr=0, state=ARB, lock_ch=0.
  - in_ready=0 while rst_n=0.
  - Reset asserted mid-packet drops the packet and any held beat. No recovery or flush beats are generated.
- Output register:
  - slot_free = ~out_valid | out_ready.
  - A transfer into the register happens only when slot_free=1 and exactly one in_ready[g]=1 with in_valid[g]=1. On that edge: out_data <= channel g data, out_sel <= g, out_last <= in_last[g], out_valid <= 1.
  - If out_valid & out_ready and no new transfer occurs, out_valid <= 0.
  - Throughput is 1 beat/cycle under continuous out_ready. Latency is 1 cycle from input handshake to out_valid.
  - While out_valid=1 and out_ready=0, out_data/out_sel/out_last are held stable.
- State ARB:
  - Grant g is the first channel with in_valid=1 scanning ptr, ptr+1, ... ptr+7, wrapping mod 8.
  - in_ready[g] = slot_free. All other in_ready bits are 0.
  - If no channel is valid, in_ready=0 and nothing changes.
  - On a transfer with in_last[g]=1: ptr <= g+1 (mod 8, so 7 wraps to 0), stay in ARB.
  - On a transfer with in_last[g]=0: lock_ch <= g, go to LOCKED. ptr is unchanged until the packet ends.
- State LOCKED:
  - in_ready[lock_ch] = slot_free. All other in_ready bits are 0, even if lock_ch is idle (in_valid low). Other channels wait.
  - On a transfer with in_last=1: ptr <= lock_ch+1 (mod 8), go to ARB.
- Combinational paths:
  - in_ready depends combinationally on out_ready, state, ptr and in_valid.
  - in_ready does not depend on in_data or in_last.
- Fairness: with all 8 channels continuously valid and single-beat packets, grants rotate 0,1,...,7,0 with no channel skipped.
- Simultaneous events: a drain (out_ready=1) and a new load in the same cycle keep out_valid=1 with the new beat. There is no bubble.
- Input contract: in_valid[i] must not be withdrawn before acceptance. Violations are not checked.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles with in_valid=8'hFF -> in_ready=0, out_valid=0, out_sel=0. Release rst_n with out_ready=1 -> the first beat presented has out_sel=0.
- Round-robin rotation: all 8 channels valid, in_last=8'hFF, channel i data = 8'h10+i, out_ready=1 -> out_sel sequence 0..7,0, out_data 8'h10..8'h17, one beat/cycle, in_ready exactly one-hot each cycle.
- Pointer wrap and skip: only channels 2 and 6 valid, ptr=0 -> grant 2, then 6, then 2. After the grant on channel 6, ptr=7 and the scan wraps through 7 to grant 2.
- Packet lock: channel 3 sends a 4-beat packet (last on beat 4) while channel 4 is valid the whole time -> 4 consecutive beats with out_sel=3, channel 4 in_ready=0 throughout, then channel 4 is granted next.
- Backpressure: out_ready=0 for 5 cycles after the first beat is loaded -> out_data/out_sel stable, in_ready=0 throughout. Raise out_ready -> drain and a new load occur in the same cycle, no bubble.
- Reset mid-packet: drop rst_n during beat 2 of a 4-beat packet on channel 5 -> the next cycle shows out_valid=0, state=ARB, ptr=0. Afterwards channel 0 is granted before channel 5 when both are valid.
